// File: rtl/sdram_pro_traffic_gen.sv
// -----------------------------------------------------------------------------
// sdram_pro_traffic_gen
//
// Single-clock traffic source/sink for the SDRAM FIFO controller top. A run
// pushes TOTAL_WORDS pattern words into the write FIFO. It waits for the write
// FIFO to empty and then for DRAIN_CYC further cycles. It then enables SDRAM
// reads, pops the read FIFO and compares every returned word against the same
// pattern sequence.
//
// Optional build macro: TRAFFIC_GEN_LFSR_EN
//   defined   : pattern is a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1);
//               a zero SEED is replaced by 16'h0001
//   undefined : pattern increments by one, modulo 2^16
//
// Ports:
//   sys_clk          system clock, all logic on the rising edge
//   sys_rst_n        synchronous active-low reset
//   start            one-cycle pulse, begins a run from IDLE or DONE
//   init_end         SDRAM initialisation complete; a fall mid-run aborts it
//   wr_fifo_num      write FIFO fill level
//   wr_fifo_wr_req   write FIFO push
//   wr_fifo_wr_data  write FIFO data, valid with wr_fifo_wr_req
//   rd_fifo_num      read FIFO fill level
//   rd_fifo_rd_req   read FIFO pop
//   rd_fifo_rd_data  read FIFO data, valid the cycle after rd_fifo_rd_req
//   read_valid       SDRAM read enable to the controller
//   busy             run in progress
//   done             run finished, held until the next start or reset
//   pass             valid with done; 1 when no mismatch was seen
//   err_cnt          saturating mismatch count
// -----------------------------------------------------------------------------
module sdram_pro_traffic_gen #(
   parameter int          TOTAL_WORDS = 1024,
   parameter int          FIFO_HIGH   = 512,
   parameter int          DRAIN_CYC   = 64,
   parameter logic [15:0] SEED        = 16'h0001
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        start,
   input  logic        init_end,
   input  logic [9:0]  wr_fifo_num,
   output logic        wr_fifo_wr_req,
   output logic [15:0] wr_fifo_wr_data,
   input  logic [9:0]  rd_fifo_num,
   output logic        rd_fifo_rd_req,
   input  logic [15:0] rd_fifo_rd_data,
   output logic        read_valid,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] err_cnt
);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_INIT, S_WRITE, S_DRAIN, S_READ, S_CHECK_TAIL, S_DONE
   } state_t;

   localparam logic [16:0] LP_TOTAL      = 17'(TOTAL_WORDS);
   localparam logic [10:0] LP_HIGH       = 11'(FIFO_HIGH);
   localparam logic [16:0] LP_DRAIN_LAST = (DRAIN_CYC > 1) ? 17'(DRAIN_CYC - 1) : 17'd0;
`ifdef TRAFFIC_GEN_LFSR_EN
   // An all-zero LFSR never leaves zero.
   localparam logic [15:0] LP_SEED = (SEED == 16'h0000) ? 16'h0001 : SEED;
`else
   localparam logic [15:0] LP_SEED = SEED;
`endif

   // Shared by the write and read sides so both walk the same sequence.
   function automatic logic [15:0] f_next_pat(input logic [15:0] cur);
`ifdef TRAFFIC_GEN_LFSR_EN
      return {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
`else
      return cur + 16'd1;
`endif
   endfunction

   state_t      r_state,     w_state_nxt;
   logic [16:0] r_wr_cnt,    w_wr_cnt_nxt;
   logic [16:0] r_rd_cnt,    w_rd_cnt_nxt;
   logic [16:0] r_drain_cnt, w_drain_cnt_nxt;
   logic [15:0] r_wr_pat,    w_wr_pat_nxt;
   logic [15:0] r_rd_pat,    w_rd_pat_nxt;
   logic [15:0] r_err_cnt,   w_err_cnt_nxt;
   logic        r_rd_req_d;  // pop issued last cycle == read data valid now

   logic w_active;
   logic w_abort;
   logic w_wr_req;
   logic w_rd_room;
   logic w_rd_req;

   assign w_active = (r_state == S_WRITE) || (r_state == S_DRAIN) ||
                     (r_state == S_READ)  || (r_state == S_CHECK_TAIL);
   assign w_abort  = w_active && !init_end;

   // Requests are gated by init_end directly so an abort silences them in the
   // very cycle the fall is seen.
   assign w_wr_req = (r_state == S_WRITE) && init_end &&
                     ({1'b0, wr_fifo_num} < LP_HIGH) && (r_wr_cnt < LP_TOTAL);

   // rd_fifo_num does not yet reflect last cycle's pop, so a level of one
   // only allows a pop if nothing was popped last cycle.
   assign w_rd_room = (rd_fifo_num >= 10'd2) || ((rd_fifo_num == 10'd1) && !r_rd_req_d);
   assign w_rd_req  = (r_state == S_READ) && init_end && (r_rd_cnt < LP_TOTAL) && w_rd_room;

   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      w_state_nxt     = r_state;
      w_wr_cnt_nxt    = r_wr_cnt;
      w_rd_cnt_nxt    = r_rd_cnt;
      w_drain_cnt_nxt = r_drain_cnt;
      w_wr_pat_nxt    = r_wr_pat;
      w_rd_pat_nxt    = r_rd_pat;
      w_err_cnt_nxt   = r_err_cnt;

      // Check stage: one cycle behind the pop.
      if (r_rd_req_d) begin
         w_rd_pat_nxt = f_next_pat(r_rd_pat);
         if ((rd_fifo_rd_data != r_rd_pat) && (r_err_cnt != 16'hFFFF))
            w_err_cnt_nxt = r_err_cnt + 16'd1;
      end

      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_state_nxt   = S_WAIT_INIT;
               w_wr_cnt_nxt  = '0;
               w_rd_cnt_nxt  = '0;
               w_wr_pat_nxt  = LP_SEED;
               w_rd_pat_nxt  = LP_SEED;
               w_err_cnt_nxt = '0;
            end
         end
         S_WAIT_INIT: begin
            if (init_end) begin
               w_state_nxt     = S_WRITE;
               w_drain_cnt_nxt = '0;
            end
         end
         S_WRITE: begin
            if (w_wr_req) begin
               w_wr_pat_nxt = f_next_pat(r_wr_pat);
               w_wr_cnt_nxt = r_wr_cnt + 17'd1;
               if (r_wr_cnt + 17'd1 == LP_TOTAL)
                  w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // The count starts on the first empty cycle and then runs freely.
            if ((r_drain_cnt != 17'd0) || (wr_fifo_num == 10'd0)) begin
               if (r_drain_cnt == LP_DRAIN_LAST)
                  w_state_nxt = S_READ;
               else
                  w_drain_cnt_nxt = r_drain_cnt + 17'd1;
            end
         end
         S_READ: begin
            if (w_rd_req) begin
               w_rd_cnt_nxt = r_rd_cnt + 17'd1;
               if (r_rd_cnt + 17'd1 == LP_TOTAL)
                  w_state_nxt = S_CHECK_TAIL;
            end
         end
         S_CHECK_TAIL: w_state_nxt = S_DONE;  // last compare lands here
         default:      w_state_nxt = S_IDLE;
      endcase

      if (w_abort)
         w_state_nxt = S_IDLE;
   end

   always_ff @(posedge sys_clk) begin
      // NOTE: reset is synchronous; it only takes effect on a rising edge.
      if (!sys_rst_n) begin
         r_state     <= S_IDLE;
         r_wr_cnt    <= '0;
         r_rd_cnt    <= '0;
         r_drain_cnt <= '0;
         r_wr_pat    <= LP_SEED;
         r_rd_pat    <= LP_SEED;
         r_err_cnt   <= '0;
         r_rd_req_d  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         r_state     <= w_state_nxt;
         r_wr_cnt    <= w_wr_cnt_nxt;
         r_rd_cnt    <= w_rd_cnt_nxt;
         r_drain_cnt <= w_drain_cnt_nxt;
         r_wr_pat    <= w_wr_pat_nxt;
         r_rd_pat    <= w_rd_pat_nxt;
         r_err_cnt   <= w_err_cnt_nxt;
         r_rd_req_d  <= w_rd_req;
      end
   end

   assign wr_fifo_wr_req  = w_wr_req;
   assign wr_fifo_wr_data = w_wr_req ? r_wr_pat : 16'h0000;
   assign rd_fifo_rd_req  = w_rd_req;
   assign read_valid      = (r_state == S_READ) && init_end;
   assign busy            = w_active || (r_state == S_WAIT_INIT);
   assign done            = (r_state == S_DONE);
   assign pass            = (r_state == S_DONE) && (r_err_cnt == 16'h0000);
   assign err_cnt         = r_err_cnt;

endmodule

// File: tb/tb_sdram_pro_traffic_gen.sv
// -----------------------------------------------------------------------------
// tb_sdram_pro_traffic_gen
//
// Drives sdram_pro_traffic_gen through a loopback of ideal queues standing in
// for the write FIFO, the SDRAM and the read FIFO, with random transfer stalls.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_sdram_pro_traffic_gen;

   localparam int          TOTAL_WORDS = 16;
   localparam int          FIFO_HIGH   = 512;
   localparam int          DRAIN_CYC   = 8;
   localparam logic [15:0] SEED        = 16'hFFFE;

   logic        sys_clk         = 1'b0;
   logic        sys_rst_n       = 1'b0;
   logic        start           = 1'b0;
   logic        init_end        = 1'b0;
   logic [9:0]  wr_fifo_num     = '0;
   logic [9:0]  rd_fifo_num     = '0;
   logic [15:0] rd_fifo_rd_data = '0;
   logic        wr_fifo_wr_req;
   logic [15:0] wr_fifo_wr_data;
   logic        rd_fifo_rd_req;
   logic        read_valid;
   logic        busy;
   logic        done;
   logic        pass;
   logic [15:0] err_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   sdram_pro_traffic_gen #(
      .TOTAL_WORDS (TOTAL_WORDS),
      .FIFO_HIGH   (FIFO_HIGH),
      .DRAIN_CYC   (DRAIN_CYC),
      .SEED        (SEED)
   ) dut (
      .sys_clk         (sys_clk),
      .sys_rst_n       (sys_rst_n),
      .start           (start),
      .init_end        (init_end),
      .wr_fifo_num     (wr_fifo_num),
      .wr_fifo_wr_req  (wr_fifo_wr_req),
      .wr_fifo_wr_data (wr_fifo_wr_data),
      .rd_fifo_num     (rd_fifo_num),
      .rd_fifo_rd_req  (rd_fifo_rd_req),
      .rd_fifo_rd_data (rd_fifo_rd_data),
      .read_valid      (read_valid),
      .busy            (busy),
      .done            (done),
      .pass            (pass),
      .err_cnt         (err_cnt)
   );

   always #5 sys_clk = ~sys_clk;

   // Expected i-th word of a run, straight from the pattern definition.
   function automatic logic [15:0] pat(input int i);
`ifdef TRAFFIC_GEN_LFSR_EN
      logic [15:0] v;
      v = (SEED == 16'h0000) ? 16'h0001 : SEED;
      for (int k = 0; k < i; k++) v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
      return v;
`else
      return 16'((32'(SEED) + i) % 65536);
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------------------------------------------------------- model
   logic [15:0] wq[$];        // write FIFO
   logic [15:0] mq[$];        // SDRAM
   logic [15:0] rq[$];        // read FIFO
   logic [15:0] push_log[$];  // every word pushed this run
   int          n_pops       = 0;
   int          corrupt_idx  = -1;
   bit          rd_toggle    = 1'b0;
   bit          toggle_phase = 1'b0;
   int          hold_state   = 0;  // 0 off, 1 armed, 2 holding, 3 resume cycle, 4 finished
   int          hold_cnt     = 0;
   int          hold_pushes  = 0;
   bit          resume_push  = 1'b0;
   int          viol_empty   = 0;
   int          viol_b2b     = 0;
   bit          prev_pop     = 1'b0;
   bit          s_rd_valid   = 1'b0;
   logic [15:0] s_rd_data    = '0;
   int          p_wr         = 0;
   int          p_rd         = 0;

   initial begin
      forever begin
         @(posedge sys_clk);
         #1;
         p_wr = wq.size();
         if (hold_state == 1 && push_log.size() >= 4) begin
            hold_state = 2;
            hold_cnt   = 0;
         end
         if (hold_state == 2) begin
            p_wr = FIFO_HIGH;
            hold_cnt++;
         end else if (hold_state == 3) begin
            p_wr = FIFO_HIGH - 1;
         end
         p_rd = rq.size();
         if (rd_toggle) begin
            toggle_phase = !toggle_phase;
            p_rd = (toggle_phase && rq.size() > 0) ? 1 : 0;
         end
         wr_fifo_num     = 10'(p_wr);
         rd_fifo_num     = 10'(p_rd);
         rd_fifo_rd_data = s_rd_valid ? s_rd_data : 16'($urandom);

         @(negedge sys_clk);
         if (wr_fifo_wr_req === 1'b1) begin
            wq.push_back(wr_fifo_wr_data);
            push_log.push_back(wr_fifo_wr_data);
            if (hold_state == 2) hold_pushes++;
         end
         if (hold_state == 3) begin
            resume_push = (wr_fifo_wr_req === 1'b1);
            hold_state  = 4;
         end else if (hold_state == 2 && hold_cnt == 100) begin
            hold_state = 3;
         end
         s_rd_valid = 1'b0;
         if (rd_fifo_rd_req === 1'b1) begin
            if (p_rd == 0 || rq.size() == 0) viol_empty++;
            if (p_rd == 1 && prev_pop) viol_b2b++;
            if (rq.size() > 0) begin
               s_rd_data = rq.pop_front();
               if (n_pops == corrupt_idx) s_rd_data ^= 16'h0001;
               s_rd_valid = 1'b1;
            end
            n_pops++;
         end
         prev_pop = (rd_fifo_rd_req === 1'b1);
         if (wq.size() > 0 && hold_state != 2 && $urandom_range(3) != 0)
            mq.push_back(wq.pop_front());
         if (read_valid === 1'b1 && mq.size() > 0 && $urandom_range(3) != 0)
            rq.push_back(mq.pop_front());
      end
   end

   // ---------------------------------------------------------------- helpers
   task automatic tick();
      @(posedge sys_clk);
      #2;
   endtask

   task automatic flush();
      tick();
      wq.delete();
      mq.delete();
      rq.delete();
      push_log.delete();
      n_pops      = 0;
      corrupt_idx = -1;
      rd_toggle   = 1'b0;
      hold_state  = 0;
      hold_pushes = 0;
      resume_push = 1'b0;
      viol_empty  = 0;
      viol_b2b    = 0;
      prev_pop    = 1'b0;
      s_rd_valid  = 1'b0;
   endtask

   task automatic pulse_start();
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      @(negedge sys_clk);
      while (done !== 1'b1 && n < 4000) begin
         @(negedge sys_clk);
         n++;
      end
      check({tag, "_reached_done"}, 32'(done), 32'd1);
   endtask

   task automatic wait_pushes(input string tag, input int cnt);
      int n = 0;
      while (push_log.size() < cnt && n < 2000) begin
         @(negedge sys_clk);
         n++;
      end
      check({tag, "_pushes_seen"}, 32'(push_log.size() >= cnt), 32'd1);
   endtask

   task automatic check_end(input string tag, input int exp_err, input bit exp_pass);
      @(negedge sys_clk);
      check({tag, "_done"},       32'(done),       32'd1);
      check({tag, "_pass"},       32'(pass),       32'(exp_pass));
      check({tag, "_err_cnt"},    32'(err_cnt),    32'(exp_err));
      check({tag, "_busy"},       32'(busy),       32'd0);
      check({tag, "_read_valid"}, 32'(read_valid), 32'd0);
      check({tag, "_pops"},       32'(n_pops),     32'(TOTAL_WORDS));
      check({tag, "_pop_empty"},  32'(viol_empty), 32'd0);
   endtask

   task automatic check_pushes(input string tag);
      check({tag, "_push_count"}, 32'(push_log.size()), 32'(TOTAL_WORDS));
      for (int i = 0; i < push_log.size() && i < TOTAL_WORDS; i++)
         check($sformatf("%s_push%0d", tag, i), 32'(push_log[i]), 32'(pat(i)));
   endtask

   // ---------------------------------------------------------------- watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------- sequence
   initial begin
      int n;
      int sz;

      // Reset state
      repeat (4) @(posedge sys_clk);
      @(negedge sys_clk);
      check("rst_busy",       32'(busy),            32'd0);
      check("rst_done",       32'(done),            32'd0);
      check("rst_pass",       32'(pass),            32'd0);
      check("rst_err_cnt",    32'(err_cnt),         32'd0);
      check("rst_wr_req",     32'(wr_fifo_wr_req),  32'd0);
      check("rst_wr_data",    32'(wr_fifo_wr_data), 32'd0);
      check("rst_rd_req",     32'(rd_fifo_rd_req),  32'd0);
      check("rst_read_valid", 32'(read_valid),      32'd0);
      tick();
      sys_rst_n = 1'b1;

      // Run 1: clean loopback, pattern wraps through 0000, start while busy ignored
      flush();
      pulse_start();
      @(negedge sys_clk);
      check("run1_busy_after_start", 32'(busy),           32'd1);
      check("run1_no_push_pre_init", 32'(wr_fifo_wr_req), 32'd0);
      repeat (5) tick();
      init_end = 1'b1;
      wait_pushes("run1", 6);
      pulse_start();
      wait_done("run1");
      check_end("run1", 0, 1'b1);
      check_pushes("run1");
      check("run1_b2b_at_one", 32'(viol_b2b), 32'd0);

      // Run 2: fifth returned word corrupted
      flush();
      corrupt_idx = 4;
      pulse_start();
      wait_done("run2");
      check_end("run2", 1, 1'b0);

      // Run 3: write FIFO held full for 100 cycles mid-write
      flush();
      hold_state = 1;
      pulse_start();
      wait_done("run3");
      check_end("run3", 0, 1'b1);
      check("run3_hold_ran",       32'(hold_state),  32'd4);
      check("run3_hold_pushes",    32'(hold_pushes), 32'd0);
      check("run3_resume_at_511",  32'(resume_push), 32'd1);
      check("run3_push_count",     32'(push_log.size()), 32'(TOTAL_WORDS));

      // Run 4: read FIFO level toggling between 1 and 0
      flush();
      rd_toggle = 1'b1;
      pulse_start();
      wait_done("run4");
      check_end("run4", 0, 1'b1);
      check("run4_b2b_at_one", 32'(viol_b2b), 32'd0);

      // Run 5: init_end drops during READ, then a clean rerun
      flush();
      pulse_start();
      n = 0;
      while (!(read_valid === 1'b1 && n_pops >= 3) && n < 4000) begin
         @(negedge sys_clk);
         n++;
      end
      check("run5_reached_read", 32'(read_valid === 1'b1 && n_pops >= 3), 32'd1);
      @(posedge sys_clk);
      #1;
      init_end = 1'b0;
      @(negedge sys_clk);
      check("run5_abort_read_valid", 32'(read_valid),     32'd0);
      check("run5_abort_rd_req",     32'(rd_fifo_rd_req), 32'd0);
      @(negedge sys_clk);
      check("run5_abort_busy",    32'(busy),    32'd0);
      check("run5_abort_done",    32'(done),    32'd0);
      check("run5_abort_pass",    32'(pass),    32'd0);
      check("run5_abort_err_cnt", 32'(err_cnt), 32'd0);
      flush();
      init_end = 1'b1;
      pulse_start();
      wait_done("run5b");
      check_end("run5b", 0, 1'b1);
      check_pushes("run5b");

      // Run 6: reset mid-write
      flush();
      pulse_start();
      wait_pushes("run6", 3);
      @(posedge sys_clk);
      #1;
      sys_rst_n = 1'b0;
      tick();
      sz = push_log.size();
      @(negedge sys_clk);
      check("run6_rst_wr_req",  32'(wr_fifo_wr_req), 32'd0);
      check("run6_rst_busy",    32'(busy),           32'd0);
      check("run6_rst_err_cnt", 32'(err_cnt),        32'd0);
      repeat (3) @(negedge sys_clk);
      check("run6_no_push_after_rst", 32'(push_log.size()), 32'(sz));
      tick();
      sys_rst_n = 1'b1;
      repeat (2) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
